// File: rtl/prng_range_sampler.sv
// Turns raw PRNG words into uniform values in [0, limit) by mask-and-reject,
// with a bounded number of draws and a deterministic fold-down fallback.
module prng_range_sampler #(
  parameter int MAX_TRIES = 8,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic [7:0]       rsp_tries,
  output logic             rsp_fallback,
  output logic             rand_next,
  input  logic [WIDTH-1:0] rand_num,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never depends combinationally on ready and payload is held while valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MASK  = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [7:0]       tries_q, tries_d;
  logic [WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic [7:0]       rsp_tries_q, rsp_tries_d;
  logic             rsp_fallback_q, rsp_fallback_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rand_next_q, rand_next_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cand;

  // Smallest 2^k-1 covering x; limit=0 wraps to all ones, limit=1 gives 0.
  function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    m = x;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  assign cand = rand_num & mask_q;

  always_comb begin
    state_d        = state_q;
    limit_d        = limit_q;
    mask_d         = mask_q;
    tries_d        = tries_q;
    rsp_value_d    = rsp_value_q;
    rsp_tries_d    = rsp_tries_q;
    rsp_fallback_d = rsp_fallback_q;
    rsp_valid_d    = rsp_valid_q;
    rand_next_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          limit_d = req_limit;
          tries_d = 8'd0;
          state_d = S_MASK;
        end
      end
      S_MASK: begin
        mask_d      = smear(limit_q - WIDTH'(1));
        rand_next_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        tries_d = tries_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (limit_q == '0 || cand < limit_q) begin
          rsp_value_d    = cand;
          rsp_fallback_d = 1'b0;
          rsp_tries_d    = tries_q;
          rsp_valid_d    = 1'b1;
          state_d        = S_RESP;
        end else if (tries_q == 8'(MAX_TRIES)) begin
          // cand < 2*limit because mask < 2*limit, so this lands in range
          rsp_value_d    = cand - limit_q;
          rsp_fallback_d = 1'b1;
          rsp_tries_d    = tries_q;
          rsp_valid_d    = 1'b1;
          state_d        = S_RESP;
        end else begin
          rand_next_d = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      limit_q        <= '0;
      mask_q         <= '0;
      tries_q        <= 8'd0;
      rsp_value_q    <= '0;
      rsp_tries_q    <= 8'd0;
      rsp_fallback_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rand_next_q    <= 1'b0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      limit_q        <= limit_d;
      mask_q         <= mask_d;
      tries_q        <= tries_d;
      rsp_value_q    <= rsp_value_d;
      rsp_tries_q    <= rsp_tries_d;
      rsp_fallback_q <= rsp_fallback_d;
      rsp_valid_q    <= rsp_valid_d;
      rand_next_q    <= rand_next_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_value    = rsp_value_q;
  assign rsp_tries    = rsp_tries_q;
  assign rsp_fallback = rsp_fallback_q;
  assign rand_next    = rand_next_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_prng_range_sampler.sv
// Bench for prng_range_sampler: a stub PRNG feeds queued words on each rand_next
// pulse; a reference model predicts each response into a scoreboard queue.
module tb_prng_range_sampler;
  localparam int W  = 32;
  localparam int MT = 4;
  localparam int EW = W + 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_limit;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_value;
  logic [7:0]   rsp_tries;
  logic         rsp_fallback;
  logic         rand_next;
  logic [W-1:0] rand_num = '0;
  logic         busy;
  logic [2:0]   dbg_state;

  prng_range_sampler #(.MAX_TRIES(MT), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_limit(req_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value),
    .rsp_tries(rsp_tries), .rsp_fallback(rsp_fallback),
    .rand_next(rand_next), .rand_num(rand_num),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stub PRNG: a pulse seen in cycle c presents the next word from cycle c+1 on
  logic [W-1:0] stub_q[$];
  logic [W-1:0] stub_last = '0;
  int           pulses = 0;
  int           pulse_cyc[$];
  always @(negedge clk) begin
    if (rand_next === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      if (stub_q.size() > 0) stub_last = stub_q.pop_front();
      rand_num = stub_last;
    end
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: mask grown bit by bit, then walk the words the stub will hand out.
  function automatic logic [EW-1:0] model(input logic [W-1:0] lim);
    logic [W-1:0] mask, w, cand;
    int idx;
    w = stub_last;
    idx = 0;
    if (lim == '0) mask = '1;
    else begin
      mask = '0;
      while (mask < lim - W'(1)) mask = (mask << 1) | W'(1);
    end
    for (int t = 1; t <= MT; t++) begin
      if (idx < stub_q.size()) begin
        w = stub_q[idx];
        idx++;
      end
      cand = w & mask;
      if (lim == '0 || cand < lim) return {1'b0, 8'(t), cand};
      if (t == MT) return {1'b1, 8'(t), cand - lim};
    end
    return '0;
  endfunction

  // driver: one request, response check, optional rsp_ready stall, handshake
  task automatic run_req(input logic [W-1:0] lim, input int stall);
    logic [EW-1:0] e;
    logic [W-1:0]  v_hold;
    int c0, p0, budget, etries;
    logic stable;
    exp_q.push_back(model(lim));
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    pulse_cyc.delete();
    p0 = pulses;
    req_valid = 1'b1;
    req_limit = lim;
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_limit = $urandom();
    budget = 0;
    while (rsp_valid !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (rsp_valid !== 1'b1) begin
      check("rsp_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    etries = int'(e[W+7:W]);
    check("rsp_value", rsp_value, e[W-1:0]);
    check("rsp_tries", rsp_tries, e[W+7:W]);
    check("rsp_fallback", rsp_fallback, e[W+8]);
    check("latency", cyc - c0, 5 + 3 * (etries - 1));
    check("rand_pulses", pulses - p0, etries);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("pulse_gap", pulse_cyc[i] - pulse_cyc[i-1], 3);
    if (stall > 0) begin
      v_hold = rsp_value;
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_value !== v_hold || req_ready !== 1'b0 || rand_next !== 1'b0)
          stable = 1'b0;
      end
      check("stall_stable", stable, 1);
      check("stall_no_pulse", pulses - p0, etries);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_value"}, rsp_value, 0);
    check({tag, "_rsp_tries"}, rsp_tries, 0);
    check({tag, "_rsp_fallback"}, rsp_fallback, 0);
    check({tag, "_rand_next"}, rand_next, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [W-1:0] lim;
    rst = 1'b1;
    req_valid = 1'b0;
    req_limit = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // single accepted word
    stub_q.push_back(32'h1234_5678);
    run_req(32'd10, 0);
    // two rejections
    stub_q.push_back(32'hF); stub_q.push_back(32'hC); stub_q.push_back(32'h3);
    run_req(32'd10, 0);
    // retries exhausted -> fallback
    repeat (MT) stub_q.push_back(32'hE);
    run_req(32'd10, 0);
    // full-range pass-through, then limit=1
    stub_q.push_back(32'hDEAD_BEEF);
    run_req(32'd0, 0);
    stub_q.push_back(32'hFFFF_FFFF);
    run_req(32'd1, 0);
    // long rsp_ready stall
    stub_q.push_back(32'h0000_0005);
    run_req(32'd7, 20);

    // reset while in WAIT
    stub_q.push_back(32'h0000_0002);
    p0 = pulses;
    @(negedge clk);
    req_valid = 1'b1;
    req_limit = 32'd10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wait", dbg_state, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("abort");
    check("abort_state", dbg_state, 0);
    repeat (4) @(negedge clk);
    check("abort_no_reissue", pulses - p0, 1);
    stub_q.push_back(32'h0000_0009);
    run_req(32'd10, 0);

    // random traffic
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) lim = $urandom();
      else lim = W'($urandom_range(1, 40));
      for (int k = 0; k < MT; k++) stub_q.push_back($urandom());
      run_req(lim, (n % 5 == 0) ? 3 : 0);
      stub_q.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prng_range_sampler.md
Name: prng_range_sampler

Overview:
- Downstream consumer of the PRNG core's output word stream.
- Converts raw 32-bit random words into uniformly distributed values in [0, limit) using mask-and-reject sampling.
- Has a bounded retry count and a deterministic fallback when retries run out.
- Sits between the PRNG core (next/num interface) and a requester (IO module or hardware engine) via valid/ready handshakes.

Parameters:
- MAX_TRIES, 8, maximum random words consumed per request before fallback (1..255).
- WIDTH, 32, width of rand_num, req_limit and rsp_value.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  sampler can accept a request (high only in IDLE)
- req_limit  input  WIDTH  exclusive upper bound; 0 = full-range pass-through
- rsp_valid  output  1  result available
- rsp_ready  input  1  requester accepts result
- rsp_value  output  WIDTH  sampled value
- rsp_tries  output  8  words consumed for this result (1..MAX_TRIES)
- rsp_fallback  output  1  result produced by the fallback path
- rand_next  output  1  one-cycle pulse requesting a new word from the PRNG core
- rand_num  input  WIDTH  current PRNG word; valid from the second cycle after the rand_next pulse
- busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, all outputs registered):
  - State = IDLE; req_ready=1.
  - rsp_valid=0, rsp_value=0, rsp_tries=0, rsp_fallback=0, rand_next=0, busy=0.
- States: IDLE, MASK, FETCH, WAIT, CHECK, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch limit; tries=0; go to MASK.
- MASK:
  - mask = OR-smear of (limit-1), i.e. smallest 2^k-1 >= limit-1.
  - limit=0 -> mask = all ones.
  - limit=1 -> mask = 0.
  - Go to FETCH.
- FETCH:
  - rand_next=1 for exactly this cycle; tries += 1; go to WAIT.
- WAIT:
  - One idle cycle; go to CHECK.
- CHECK:
  - cand = rand_num & mask.
  - If limit==0 or cand < limit (unsigned): value=cand, fallback=0 -> RESP.
  - Else if tries == MAX_TRIES: value = cand - limit, fallback=1 -> RESP. cand < 2*limit guarantees the result is in range.
  - Else -> FETCH.
- RESP:
  - rsp_valid=1; rsp_value, rsp_tries and rsp_fallback stay stable until the handshake.
  - When rsp_valid && rsp_ready: rsp_valid drops the next cycle; go to IDLE.
- Latency: request accepted in cycle 0 -> rsp_valid high in cycle 5 when the first word is accepted. Each rejection adds 3 cycles.
- Throughput: a new request is accepted at the earliest 1 cycle after the response handshake.
- Every request consumes at least one word, including limit=1 (always returns 0). This keeps the PRNG stream position deterministic.
- rand_next never asserts outside FETCH; there is never more than one outstanding word.
- req_limit changes after acceptance are ignored.
- rsp_ready held low: sampler stalls in RESP indefinitely with no further rand_next.
- rst mid-operation: abort immediately, return to IDLE with reset values. A pending rand_next is not reissued.
- All arithmetic is unsigned WIDTH-bit; no wrap occurs in cand - limit.

Test Plan:
- Reset, then stub rand_num=0x12345678, limit=10 -> mask=0xF, cand=8: rsp_value=8, rsp_tries=1, rsp_fallback=0, rsp_valid in cycle 5, exactly one rand_next pulse.
- limit=10, stub sequence 0xF, 0xC, 0x3 -> two rejections: rsp_value=3, rsp_tries=3, three rand_next pulses spaced 3 cycles apart, rsp_valid in cycle 11.
- MAX_TRIES=2, limit=10, stub always 0xE -> rsp_value=4, rsp_tries=2, rsp_fallback=1.
- limit=0, stub 0xDEADBEEF -> rsp_value=0xDEADBEEF, tries=1. Then limit=1, stub 0xFFFFFFFF -> rsp_value=0 with one rand_next pulse.
- rsp_ready low for 20 cycles -> rsp_valid and rsp_value stable, req_ready=0, no rand_next. Raise rsp_ready -> next cycle rsp_valid=0 and req_ready=1.
- Assert rst during WAIT -> next cycle IDLE, busy=0, all outputs at reset values. A new request then completes normally.
